// File: rtl/result_display_ctrl.sv
// Writeback result monitor driving DIGITS time-multiplexed active-low 7-segment digits.
// Optional unsigned-decimal display (double-dabble converter) enabled by `define DISPLAY_DEC_EN.
module result_display_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [4:0]        result_rd,
  input  logic [DATA_W-1:0] result_data,
  input  logic              watch_all,
  input  logic [4:0]        watch_rd,
  input  logic              freeze,
`ifdef DISPLAY_DEC_EN
  input  logic              dec_mode,
`endif
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic [7:0]        capture_count
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PAD_W = (4 * DIGITS > DATA_W) ? 4 * DIGITS : DATA_W;

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [DATA_W-1:0] r_held;
  logic [7:0]        r_count;
  logic [CNT_W-1:0]  r_refresh;
  logic [IDX_W-1:0]  r_idx;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;
  logic              r_dp;

  logic              w_capture;
  logic              w_tc;
  logic [PAD_W-1:0]  w_held_pad;
  logic [3:0]        w_hex_nib;
  logic              w_hex_blank;
  logic [6:0]        w_seg_next;
  logic              w_dp_next;

  assign w_capture  = result_valid && !freeze && (watch_all || (result_rd == watch_rd));
  assign w_tc       = (r_refresh == CNT_W'(REFRESH_DIV - 1));
  assign w_held_pad = PAD_W'(r_held);

  // Capture path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held  <= '0;
      r_count <= '0;
    end else if (w_capture) begin
      r_held  <= result_data;
      r_count <= r_count + 8'd1;
    end
  end

  // Refresh counter and scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else begin
      r_refresh <= w_tc ? '0 : r_refresh + CNT_W'(1);
      if (w_tc)
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Digits beyond the data width read as blank
  always_comb begin
    w_hex_nib   = '0;
    w_hex_blank = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_hex_nib   = w_held_pad[4*i +: 4];
        w_hex_blank = (4 * i >= DATA_W);
      end
    end
  end

`ifdef DISPLAY_DEC_EN
  localparam int BCD_MIN = (DATA_W * 3) / 10 + 1;
  localparam int BCD_N   = (BCD_MIN > DIGITS) ? BCD_MIN : DIGITS;
  localparam int BIT_W   = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;

  conv_state_t        r_state;
  conv_state_t        w_state_next;
  logic               r_dec_prev;
  logic [DATA_W-1:0]  r_bin;
  logic [4*BCD_N-1:0] r_work;
  logic [4*BCD_N-1:0] r_bcd;
  logic [BIT_W-1:0]   r_bit;
  logic [4*BCD_N-1:0] w_adj;
  logic               w_start;
  logic [DATA_W-1:0]  w_start_val;
  logic               w_last;
  logic [3:0]         w_bcd_nib;
  logic               w_ovf;

  // A fresh capture takes priority over the dec_mode edge and always restarts
  assign w_start     = w_capture || (dec_mode && !r_dec_prev);
  assign w_start_val = w_capture ? result_data : r_held;
  assign w_last      = (r_bit == BIT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_start) w_state_next = S_SHIFT;
               else if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = w_start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_work;
    for (int unsigned k = 0; k < BCD_N; k++) begin
      if (r_work[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_prev <= 1'b0;
      r_bin      <= '0;
      r_work     <= '0;
      r_bcd      <= '0;
      r_bit      <= '0;
    end else begin
      r_dec_prev <= dec_mode;
      if (w_start) begin
        r_bin  <= w_start_val;
        r_work <= '0;
        r_bit  <= '0;
      end else if (r_state == S_SHIFT) begin
        r_work <= {w_adj[4*BCD_N-2:0], r_bin[DATA_W-1]};
        r_bin  <= {r_bin[DATA_W-2:0], 1'b0};
        if (!w_last) r_bit <= r_bit + BIT_W'(1);
      end
      if ((r_state == S_DONE) && !w_start)
        r_bcd <= r_work;
    end
  end

  always_comb begin
    w_bcd_nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_bcd_nib = r_bcd[4*i +: 4];
    end
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int unsigned i = DIGITS; i < BCD_N; i++) begin
      w_ovf = w_ovf | (|r_bcd[4*i +: 4]);
    end
  end

  always_comb begin
    w_seg_next = w_hex_blank ? 7'h7F : f_seg(w_hex_nib);
    w_dp_next  = 1'b1;
    if (dec_mode) begin
      w_seg_next = f_seg(w_bcd_nib);
      w_dp_next  = !((r_idx == IDX_W'(DIGITS - 1)) && w_ovf);
    end
  end
`else
  always_comb begin
    w_seg_next = w_hex_blank ? 7'h7F : f_seg(w_hex_nib);
    w_dp_next  = 1'b1;
  end
`endif

  // seg/an/dp all derive from the same r_idx, so they switch together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_dp  <= w_dp_next;
    end
  end

  assign seg           = r_seg;
  assign an            = r_an;
  assign dp            = r_dp;
  assign capture_count = r_count;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Scoreboard bench for result_display_ctrl: a 32-bit and an 8-bit instance sharing stimulus.
module tb_result_display_ctrl;

  localparam int DW  = 32;
  localparam int DG  = 4;
  localparam int RD  = 4;
  localparam int RD8 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        result_valid = 1'b0;
  logic [4:0]  result_rd = '0;
  logic [31:0] result_data = '0;
  logic        watch_all = 1'b1;
  logic [4:0]  watch_rd = '0;
  logic        freeze = 1'b0;
  logic        dec_mode = 1'b0;
  logic [6:0]  seg, seg8;
  logic [3:0]  an, an8;
  logic        dp, dp8;
  logic [7:0]  capture_count, capture_count8;

  result_display_ctrl #(.DATA_W(DW), .DIGITS(DG), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result_rd(result_rd),
    .result_data(result_data), .watch_all(watch_all), .watch_rd(watch_rd),
    .freeze(freeze),
`ifdef DISPLAY_DEC_EN
    .dec_mode(dec_mode),
`endif
    .seg(seg), .an(an), .dp(dp), .capture_count(capture_count));

  result_display_ctrl #(.DATA_W(8), .DIGITS(DG), .REFRESH_DIV(RD8)) dut8 (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result_rd(result_rd),
    .result_data(result_data[7:0]), .watch_all(watch_all), .watch_rd(watch_rd),
    .freeze(freeze),
`ifdef DISPLAY_DEC_EN
    .dec_mode(dec_mode),
`endif
    .seg(seg8), .an(an8), .dp(dp8), .capture_count(capture_count8));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] sb_q[$];
  logic [31:0] exp_held = '0;
  logic [7:0]  exp_cnt = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [11:0] obs(input bit narrow);
    return narrow ? {dp8, an8, seg8} : {dp, an, seg};
  endfunction

  task automatic push_hex(input logic [31:0] v, input int width);
    logic [3:0] a;
    logic [6:0] s;
    for (int d = 0; d < DG; d++) begin
      a = ~(4'b0001 << d);
      s = (4 * d >= width) ? 7'h7F : seg_of(v[4*d +: 4]);
      sb_q.push_back({1'b1, a, s});
    end
  endtask

  task automatic push_dec(input int unsigned v);
    logic [3:0]  a;
    int unsigned x;
    logic        p;
    x = v;
    for (int d = 0; d < DG; d++) begin
      a = ~(4'b0001 << d);
      p = !((d == DG - 1) && (v >= 10000));
      sb_q.push_back({p, a, seg_of(4'(x % 10))});
      x = x / 10;
    end
  endtask

  // Pops DG expected digits and compares them against one full scan
  task automatic scan_compare(input string name, input bit narrow);
    logic [11:0] e, o;
    int          per, lim;
    per = narrow ? RD8 : RD;
    lim = 2 * DG * per + 4;
    @(negedge clk);
    for (int i = 0; i < lim && obs(narrow)[10:7] !== 4'b1110; i++) @(negedge clk);
    if (obs(narrow)[10:7] !== 4'b1110) begin
      n_cmp++; n_err++;
      $display("FAIL %s: digit 0 enable never seen, an=%b", name, obs(narrow)[10:7]);
      repeat (DG) void'(sb_q.pop_front());
      return;
    end
    for (int d = 0; d < DG; d++) begin
      e = sb_q.pop_front();
      o = obs(narrow);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s digit%0d: got dp=%b an=%b seg=%h, want dp=%b an=%b seg=%h",
                 name, d, o[11], o[10:7], o[6:0], e[11], e[10:7], e[6:0]);
      end
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic drive_write(input logic [4:0] rd, input logic [31:0] data);
    result_valid = 1'b1;
    result_rd    = rd;
    result_data  = data;
    if (!freeze && (watch_all || rd == watch_rd)) begin
      exp_held = data;
      exp_cnt  = exp_cnt + 8'd1;
    end
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic check_count(input string name);
    n_cmp++;
    if (capture_count !== exp_cnt) begin
      n_err++;
      $display("FAIL %s: capture_count=%0d want %0d", name, capture_count, exp_cnt);
    end
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_write(5'd1, 32'h0000_00AB);
    repeat (2 * RD + 1) @(negedge clk);
    #2 rst = 1'b1;
    exp_held = '0;
    exp_cnt  = '0;
    #1;
    n_cmp++;
    if ({seg, an, dp, capture_count} !== {7'h7F, 4'hF, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL reset_state: seg=%h an=%b dp=%b count=%0d want 7f 1111 1 0",
               seg, an, dp, capture_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_first_an: an=%b want 1110", an);
    end
    n = 1;
    while (an === 4'b1110 && n < 4 * RD) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n - 1 != RD || an !== 4'b1101) begin
      n_err++;
      $display("FAIL reset_refresh_period: digit0 held %0d cycles then an=%b, want %0d then 1101",
               n - 1, an, RD);
    end
    check_count("reset_count");
    push_hex(32'h0, DW);
    scan_compare("reset_zero", 1'b0);
  endtask

  task automatic test_hex_capture;
    watch_all = 1'b1;
    drive_write(5'd7, 32'h0000_BEEF);
    check_count("beef_count");
    push_hex(exp_held, DW);
    scan_compare("beef_scan", 1'b0);
  endtask

  task automatic test_watch_filter;
    watch_all = 1'b0;
    watch_rd  = 5'd5;
    drive_write(5'd3, 32'h11);
    drive_write(5'd5, 32'h22);
    check_count("filter_count");
    push_hex(32'h22, DW);
    scan_compare("filter_scan", 1'b0);
    watch_all = 1'b1;
  endtask

  task automatic test_freeze;
    freeze = 1'b1;
    drive_write(5'd5, 32'h1234);
    check_count("freeze_count");
    push_hex(32'h22, DW);
    scan_compare("freeze_hold", 1'b0);
    freeze = 1'b0;
    drive_write(5'd5, 32'h1234);
    check_count("unfreeze_count");
    push_hex(32'h1234, DW);
    scan_compare("unfreeze_scan", 1'b0);
  endtask

  task automatic test_back_to_back;
    result_valid = 1'b1;
    result_rd    = 5'd9;
    result_data  = 32'hCAFE_0001;
    @(negedge clk);
    result_data  = 32'h0000_ABCD;
    @(negedge clk);
    result_valid = 1'b0;
    exp_held = 32'h0000_ABCD;
    exp_cnt  = exp_cnt + 8'd2;
    check_count("b2b_count");
    push_hex(exp_held, DW);
    scan_compare("b2b_scan", 1'b0);
  endtask

  task automatic test_count_wrap;
    int n;
    n = 256 - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      drive_write(5'd2, 32'h5A00 + i);
      if (i == n - 2) check_count("count_255");
    end
    check_count("count_wrap");
  endtask

  task automatic test_narrow;
    drive_write(5'd4, 32'h1234_56A5);
    push_hex(exp_held, 8);
    scan_compare("narrow_blank", 1'b1);
    n_cmp++;
    if (capture_count8 !== exp_cnt) begin
      n_err++;
      $display("FAIL narrow_count: capture_count=%0d want %0d", capture_count8, exp_cnt);
    end
  endtask

`ifdef DISPLAY_DEC_EN
  task automatic test_dec_convert;
    dec_mode = 1'b1;
    drive_write(5'd6, 32'd9999);
    repeat (DW + 4) @(negedge clk);
    push_dec(9999);
    scan_compare("dec_9999", 1'b0);
    drive_write(5'd6, 32'd12345);
    repeat (DW + 4) @(negedge clk);
    push_dec(12345);
    scan_compare("dec_12345_ovf", 1'b0);
  endtask

  task automatic test_dec_restart;
    bit seen5;
    seen5 = 1'b0;
    drive_write(5'd6, 32'd500);
    @(negedge clk);
    drive_write(5'd6, 32'd42);
    for (int i = 0; i < DW + 2 * DG * RD; i++) begin
      if (an === 4'b1011 && seg === seg_of(4'd5)) seen5 = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen5) begin
      n_err++;
      $display("FAIL dec_restart_no500: digit2 showed 5, want never");
    end
    push_dec(42);
    scan_compare("dec_restart_42", 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_hex_capture();
    test_watch_filter();
    test_freeze();
    test_back_to_back();
    test_count_wrap();
    test_narrow();
`ifdef DISPLAY_DEC_EN
    test_dec_convert();
    test_dec_restart();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
